// File: rtl/crack_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : crack_dispatch
// Brief    : Splits a key range into CHUNK-sized sub-ranges over N_CH workers
//            and reports the first key any worker finds.
// Revision : 1.0 - initial release
// ============================================================================
module crack_dispatch #(
  parameter int KEY_W = 24,
  parameter int N_CH  = 4,
  parameter int CHUNK = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rdy,
  input  logic [KEY_W-1:0]      low_key,
  input  logic [KEY_W-1:0]      high_key,
  output logic [KEY_W-1:0]      key,
  output logic                  key_valid,
  output logic [N_CH-1:0]       ch_en,
  output logic [N_CH-1:0]       ch_stop,
  output logic [N_CH*KEY_W-1:0] ch_low,
  output logic [N_CH*KEY_W-1:0] ch_high,
  input  logic [N_CH-1:0]       ch_rdy,
  input  logic [N_CH-1:0]       ch_key_valid,
  input  logic [N_CH*KEY_W-1:0] ch_key
);

  localparam int              c_idx_w    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [KEY_W:0]  c_chunk_m1 = (KEY_W+1)'(CHUNK - 1);
  localparam logic [1:0]      c_guard    = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [KEY_W-1:0]        r_low, r_high, r_next, r_key;
  logic                    r_key_valid;
  logic [N_CH-1:0]         r_busy, r_ch_en, r_ch_stop;
  logic [N_CH-1:0][1:0]    r_guard;
  logic [N_CH*KEY_W-1:0]   r_ch_low, r_ch_high;

  logic [N_CH-1:0]         w_done, w_hit, w_idle;
  logic                    w_hit_any, w_free_any;
  logic [c_idx_w-1:0]      w_hit_idx, w_free_idx;
  logic [KEY_W:0]          w_sum;
  logic [KEY_W-1:0]        w_end, w_hit_key;
  logic                    w_accept, w_issue, w_take_hit;

  // A freshly enabled worker may still show ch_rdy=1; r_guard masks that window.
  always_comb begin
    w_done = '0;
    w_hit  = '0;
    w_idle = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_done[i] = r_busy[i] && (r_guard[i] == 2'd0) && ch_rdy[i];
      w_hit[i]  = w_done[i] && ch_key_valid[i];
      w_idle[i] = !r_busy[i] && ch_rdy[i];
    end
  end

  always_comb begin
    w_hit_any  = 1'b0;
    w_hit_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = c_idx_w'(i);
      end
      if (w_idle[i]) begin
        w_free_any = 1'b1;
        w_free_idx = c_idx_w'(i);
      end
    end
  end

  // Extra carry bit keeps next+CHUNK-1 from wrapping at the top of key space.
  assign w_sum     = {1'b0, r_next} + c_chunk_m1;
  assign w_end     = (w_sum > {1'b0, r_high}) ? r_high : w_sum[KEY_W-1:0];
  assign w_hit_key = ch_key[w_hit_idx*KEY_W +: KEY_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_take_hit  = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_accept    = 1'b1;
          w_state_nxt = DISPATCH;
        end
      end
      DISPATCH: begin
        if (r_low > r_high) begin
          w_state_nxt = DONE;
        end else if (w_hit_any) begin
          w_take_hit  = 1'b1;
          w_state_nxt = DRAIN;
        end else if (w_free_any) begin
          w_issue = 1'b1;
          if (w_end == r_high) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_hit_any && !r_key_valid) w_take_hit = 1'b1;
        if ((r_busy & ~w_done) == '0) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low       <= '0;
      r_high      <= '0;
      r_next      <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= '0;
      r_guard     <= '0;
      r_ch_en     <= '0;
      r_ch_stop   <= '0;
      r_ch_low    <= '0;
      r_ch_high   <= '0;
    end else begin
      r_ch_en   <= '0;
      r_ch_stop <= '0;
      r_busy    <= r_busy & ~w_done;
      for (int i = 0; i < N_CH; i++) begin
        if (r_guard[i] != 2'd0) r_guard[i] <= r_guard[i] - 2'd1;
      end
      if (w_accept) begin
        r_low       <= low_key;
        r_high      <= high_key;
        r_next      <= low_key;
        r_key_valid <= 1'b0;
      end
      if (w_issue) begin
        r_ch_en[w_free_idx]                  <= 1'b1;
        r_busy[w_free_idx]                   <= 1'b1;
        r_guard[w_free_idx]                  <= c_guard;
        r_ch_low[w_free_idx*KEY_W +: KEY_W]  <= r_next;
        r_ch_high[w_free_idx*KEY_W +: KEY_W] <= w_end;
        r_next                               <= w_end + 1'b1;
      end
      if (w_take_hit) begin
        r_key       <= w_hit_key;
        r_key_valid <= 1'b1;
        r_ch_stop   <= r_busy & ~w_done;
      end
    end
  end

  assign rdy       = (r_state == IDLE);
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign ch_en     = r_ch_en;
  assign ch_stop   = r_ch_stop;
  assign ch_low    = r_ch_low;
  assign ch_high   = r_ch_high;

endmodule
`default_nettype wire
